// File: rtl/data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter
//
// Shares the single data-memory port between the CPU load/store path and the
// display pixel fetcher. The CPU wins by default; a wait counter bounds how
// long the display can be refused, and once the display is forced onto the
// port it keeps it for a burst of up to BURST_LEN grants.
//
// The memory reads combinationally and writes on negedge, so all port muxing
// here is combinational and only the display read return is registered.
//
// Optional build macro: ARB_PERF_CNT_EN
//   defined   -> perf_stall_cnt / perf_force_cnt are live 32-bit counters
//   undefined -> both outputs are tied to zero, no counter flops exist
// ---------------------------------------------------------------------------
module data_mem_arbiter #(
  parameter int MAX_WAIT  = 4,      // refused display cycles before a forced grant (1..15)
  parameter int BURST_LEN = 8,      // grants per forced burst (1..15)
  parameter int IMG_LAST  = 152099  // highest byte address the display may read
) (
  input  logic        clk,
  input  logic        rst,

  // CPU load/store path
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wd,
  output logic [31:0] cpu_rd,
  output logic        cpu_stall,

  // Display pixel fetcher
  input  logic        disp_req,
  input  logic [17:0] disp_addr,
  output logic        disp_gnt,
  output logic [7:0]  disp_rdata,
  output logic        disp_rvalid,
  output logic        disp_err,

  // Data memory port
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd,

  // Performance counters (zero unless ARB_PERF_CNT_EN)
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_force_cnt
);

  typedef enum logic {
    S_CPU,   // CPU has priority, display served when CPU idle or starved
    S_DISP   // display owns the port for the remainder of a forced burst
  } state_t;

  // Who drives the memory port this cycle. OWN_NONE covers reset and an
  // out-of-range display request inside a burst: the port stays quiet.
  typedef enum logic [1:0] {
    OWN_CPU,
    OWN_DISP,
    OWN_NONE
  } owner_t;

  localparam logic [3:0]  MAX_WAIT_C  = 4'(MAX_WAIT);
  localparam logic [3:0]  BURST_LEN_C = 4'(BURST_LEN);
  localparam logic [17:0] IMG_LAST_C  = 18'(IMG_LAST);

  state_t     state, state_nxt;
  owner_t     owner;
  logic [3:0] wait_cnt, wait_cnt_nxt;
  logic [3:0] burst_cnt, burst_cnt_nxt;
  logic [3:0] burst_inc;
  logic       disp_ok;
  logic       wait_full;
  logic       forced;

  // Addresses above the image would reach the word and GPIO regions.
  assign disp_ok   = (disp_addr <= IMG_LAST_C);
  assign wait_full = (wait_cnt == MAX_WAIT_C);
  assign burst_inc = burst_cnt + 4'd1;

  // Arbitration: pick the port owner, the display grant and the next state.
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that left
    // one unassigned would infer a latch.
    owner         = OWN_CPU;
    disp_gnt      = 1'b0;
    forced        = 1'b0;
    state_nxt     = state;
    burst_cnt_nxt = burst_cnt;

    if (rst) begin
      owner = OWN_NONE;
    end else begin
      case (state)
        S_CPU: begin
          if (disp_req && !disp_ok) begin
            // Ack the bad address without touching memory; CPU unaffected.
            disp_gnt = 1'b1;
          end else if (disp_req && (!cpu_req || wait_full)) begin
            disp_gnt = 1'b1;
            owner    = OWN_DISP;
            // With cpu_req set this branch is only reachable through a full
            // wait counter, i.e. a forced grant that opens a burst.
            forced   = cpu_req;
            if (cpu_req && (BURST_LEN > 1)) begin
              state_nxt     = S_DISP;
              burst_cnt_nxt = 4'd1;
            end
          end
        end

        S_DISP: begin
          if (disp_req) begin
            disp_gnt = 1'b1;
            owner    = disp_ok ? OWN_DISP : OWN_NONE;
            if (burst_inc >= BURST_LEN_C) begin
              state_nxt     = S_CPU;
              burst_cnt_nxt = '0;
            end else begin
              burst_cnt_nxt = burst_inc;
            end
          end else begin
            // Display went quiet: hand the port straight back this cycle.
            state_nxt     = S_CPU;
            burst_cnt_nxt = '0;
          end
        end
      endcase
    end
  end

  // Memory port and CPU-side muxing driven by the chosen owner.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wd    = '0;
    cpu_rd    = '0;
    cpu_stall = cpu_req;

    case (owner)
      OWN_CPU: begin
        mem_we    = cpu_req & cpu_we;
        mem_addr  = cpu_addr;
        mem_wd    = cpu_wd;
        cpu_rd    = mem_rd;
        cpu_stall = 1'b0;
      end
      OWN_DISP: begin
        mem_addr = {14'b0, disp_addr};
      end
      default: begin
      end
    endcase
  end

  // Display starvation counter: counts refused cycles, saturates, clears on
  // a grant or when the display stops asking.
  always_comb begin
    wait_cnt_nxt = '0;
    if (disp_req && !disp_gnt) begin
      wait_cnt_nxt = wait_full ? wait_cnt : wait_cnt + 4'd1;
    end
  end

  // Arbiter state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state     <= S_CPU;
      wait_cnt  <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  // Display read return: one-cycle pulse after each grant; data holds between.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_rvalid <= 1'b0;
      disp_err    <= 1'b0;
      disp_rdata  <= '0;
    end else if (disp_gnt) begin
      disp_rvalid <= 1'b1;
      disp_err    <= !disp_ok;
      disp_rdata  <= disp_ok ? mem_rd[7:0] : 8'h00;
    end else begin
      disp_rvalid <= 1'b0;
      disp_err    <= 1'b0;
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] force_cnt_q;

  // Wrapping event counters: CPU stall cycles and forced display grants.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      force_cnt_q <= '0;
    end else begin
      if (cpu_stall) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (forced)    force_cnt_q <= force_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_force_cnt = force_cnt_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_force_cnt = '0;
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_data_mem_arbiter
//
// Directed scenarios with literal expectations, then randomized traffic.
// A behavioural reference model, expressed as "cycles refused so far" and
// "burst grants still owed", predicts every output on every cycle.
// The memory is a pure function of address so read data is predictable.
// ---------------------------------------------------------------------------
module tb_data_mem_arbiter;

  localparam int MAX_WAIT  = 4;
  localparam int BURST_LEN = 8;
  localparam int IMG_LAST  = 152099;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wd, cpu_rd;
  logic        cpu_stall;
  logic        disp_req;
  logic [17:0] disp_addr;
  logic        disp_gnt;
  logic [7:0]  disp_rdata;
  logic        disp_rvalid, disp_err;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic [31:0] perf_stall_cnt, perf_force_cnt;

  data_mem_arbiter #(
    .MAX_WAIT (MAX_WAIT),
    .BURST_LEN(BURST_LEN),
    .IMG_LAST (IMG_LAST)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_req       (cpu_req),
    .cpu_we        (cpu_we),
    .cpu_addr      (cpu_addr),
    .cpu_wd        (cpu_wd),
    .cpu_rd        (cpu_rd),
    .cpu_stall     (cpu_stall),
    .disp_req      (disp_req),
    .disp_addr     (disp_addr),
    .disp_gnt      (disp_gnt),
    .disp_rdata    (disp_rdata),
    .disp_rvalid   (disp_rvalid),
    .disp_err      (disp_err),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wd        (mem_wd),
    .mem_rd        (mem_rd),
    .perf_stall_cnt(perf_stall_cnt),
    .perf_force_cnt(perf_force_cnt)
  );

  always #5 clk = ~clk;

  // Combinational memory contents: low byte at 100 is 0xA5, at 152099 is 0xB0.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {~a[23:0], a[7:0] ^ a[15:8] ^ 8'hC1};
  endfunction

  assign mem_rd = mem_fn(mem_addr);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model and per-cycle compare
  // ---------------------------------------------------------------------
  bit          cmp_en       = 1'b0;
  int          m_refused    = 0;   // consecutive cycles the display was refused
  int          m_burst_left = 0;   // display grants still owed by a forced burst
  logic        m_rvalid     = 1'b0;
  logic        m_err        = 1'b0;
  logic [7:0]  m_rdata      = 8'h00;
  logic [31:0] m_stall_cnt  = '0;
  logic [31:0] m_force_cnt  = '0;

  always @(negedge clk) begin : model_cmp
    logic        ok, g, srv, drv, frc, stl;
    logic [31:0] word;
    if (cmp_en) begin
      // Registered outputs reflect the previous edge.
      check("rvalid", 32'(disp_rvalid), 32'(m_rvalid));
      check("err",    32'(disp_err),    32'(m_err));
      check("rdata",  32'(disp_rdata),  32'(m_rdata));
`ifdef ARB_PERF_CNT_EN
      check("perf_stall", perf_stall_cnt, m_stall_cnt);
      check("perf_force", perf_force_cnt, m_force_cnt);
`else
      check("perf_stall", perf_stall_cnt, 32'd0);
      check("perf_force", perf_force_cnt, 32'd0);
`endif

      ok  = (disp_addr <= 18'(IMG_LAST));
      g   = 1'b0;
      srv = !rst;   // CPU served unless something below takes the port
      drv = 1'b0;   // display address drives memory
      frc = 1'b0;
      if (!rst) begin
        if (m_burst_left > 0) begin
          if (disp_req) begin
            g   = 1'b1;
            srv = 1'b0;
            drv = ok;
          end
        end else if (disp_req && !ok) begin
          g = 1'b1;
        end else if (disp_req && (!cpu_req || m_refused >= MAX_WAIT)) begin
          g   = 1'b1;
          srv = 1'b0;
          drv = 1'b1;
          frc = cpu_req;
        end
      end
      stl = cpu_req && !srv;

      check("gnt",    32'(disp_gnt),  32'(g));
      check("stall",  32'(cpu_stall), 32'(stl));
      check("mem_we", 32'(mem_we),    32'(srv && cpu_req && cpu_we));
      check("cpu_rd", cpu_rd,         srv ? mem_fn(cpu_addr) : 32'd0);
      if (srv) begin
        check("mem_addr_cpu", mem_addr, cpu_addr);
        check("mem_wd_cpu",   mem_wd,   cpu_wd);
      end
      if (drv) begin
        check("mem_addr_disp", mem_addr, {14'b0, disp_addr});
        check("mem_wd_disp",   mem_wd,   32'd0);
      end

      // Advance the model across the coming edge.
      if (rst) begin
        m_refused    = 0;
        m_burst_left = 0;
        m_rvalid     = 1'b0;
        m_err        = 1'b0;
        m_rdata      = 8'h00;
        m_stall_cnt  = '0;
        m_force_cnt  = '0;
      end else begin
        if (m_burst_left > 0)
          m_burst_left = disp_req ? m_burst_left - 1 : 0;
        else if (frc)
          m_burst_left = BURST_LEN - 1;
        if (disp_req && !g)
          m_refused = (m_refused + 1 > MAX_WAIT) ? MAX_WAIT : m_refused + 1;
        else
          m_refused = 0;
        if (g) begin
          word     = mem_fn({14'b0, disp_addr});
          m_rvalid = 1'b1;
          m_err    = !ok;
          m_rdata  = ok ? word[7:0] : 8'h00;
        end else begin
          m_rvalid = 1'b0;
          m_err    = 1'b0;
        end
        m_stall_cnt = m_stall_cnt + 32'(stl);
        m_force_cnt = m_force_cnt + 32'(frc);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic cr, input logic cw,
                       input logic [31:0] ca, input logic [31:0] cwd,
                       input logic dr, input logic [17:0] da);
    rst       = r;
    cpu_req   = cr;
    cpu_we    = cw;
    cpu_addr  = ca;
    cpu_wd    = cwd;
    disp_req  = dr;
    disp_addr = da;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic g_prev;
    logic busy;

    // Reset held two cycles with both requesters active.
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0040, 32'h1111_1111, 1'b1, 18'd100);
    cyc();
    cmp_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (i > 0) cyc();
      @(negedge clk);
      check("rst_stall",  32'(cpu_stall),   32'd1);
      check("rst_gnt",    32'(disp_gnt),    32'd0);
      check("rst_mem_we", 32'(mem_we),      32'd0);
      check("rst_rvalid", 32'(disp_rvalid), 32'd0);
    end

    // Idle display read of address 100.
    cyc();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 18'd100);
    @(negedge clk);
    check("idle_gnt",   32'(disp_gnt), 32'd1);
    check("idle_addr",  mem_addr,      32'd100);
    cyc();
    disp_req = 1'b0;
    @(negedge clk);
    check("idle_rvalid", 32'(disp_rvalid), 32'd1);
    check("idle_rdata",  32'(disp_rdata),  32'h0000_00A5);
    check("idle_err",    32'(disp_err),    32'd0);

    // Starvation with a held CPU store colliding with the forced burst.
    cyc();
    drive(1'b0, 1'b1, 1'b1, 32'd152100, 32'h1234_5678, 1'b1, 18'd200);
    for (int i = 0; i <= 12; i++) begin
      if (i > 0) cyc();
      @(negedge clk);
      check("starve_stall",  32'(cpu_stall), 32'(i >= 4 && i < 12));
      check("starve_gnt",    32'(disp_gnt),  32'(i >= 4 && i < 12));
      check("starve_mem_we", 32'(mem_we),    32'(!(i >= 4 && i < 12)));
      if (i == 5) check("starve_rvalid", 32'(disp_rvalid), 32'd1);
      if (i == 12) begin
        check("store_addr", mem_addr, 32'd152100);
        check("store_wd",   mem_wd,   32'h1234_5678);
      end
    end

    // Illegal display address alongside a CPU store, then the last legal byte.
    cyc();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 18'd0);
    cyc();
    drive(1'b0, 1'b1, 1'b1, 32'h0000_1000, 32'hCAFE_F00D, 1'b1, 18'd152100);
    @(negedge clk);
    check("ill_gnt",    32'(disp_gnt),  32'd1);
    check("ill_mem_we", 32'(mem_we),    32'd1);
    check("ill_addr",   mem_addr,       32'h0000_1000);
    check("ill_stall",  32'(cpu_stall), 32'd0);
    cyc();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 18'd152099);
    @(negedge clk);
    check("ill_rvalid", 32'(disp_rvalid), 32'd1);
    check("ill_err",    32'(disp_err),    32'd1);
    check("ill_rdata",  32'(disp_rdata),  32'd0);
    check("last_gnt",   32'(disp_gnt),    32'd1);
    cyc();
    disp_req = 1'b0;
    @(negedge clk);
    check("last_err",   32'(disp_err),   32'd0);
    check("last_rdata", 32'(disp_rdata), 32'h0000_00B0);

    // Reset on the third beat of a forced burst.
    cyc();
    drive(1'b0, 1'b1, 1'b1, 32'h0000_2000, 32'h0BAD_BEEF, 1'b1, 18'd300);
    for (int i = 0; i <= 6; i++) begin
      if (i > 0) cyc();
      if (i == 6) rst = 1'b1;
      @(negedge clk);
    end
    check("mid_rst_gnt",    32'(disp_gnt),  32'd0);
    check("mid_rst_stall",  32'(cpu_stall), 32'd1);
    check("mid_rst_mem_we", 32'(mem_we),    32'd0);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_rvalid", 32'(disp_rvalid), 32'd0);
    check("post_rst_stall",  32'(cpu_stall),   32'd0);
    check("post_rst_mem_we", 32'(mem_we),      32'd1);

    // Randomized traffic; the fetcher holds its request until granted.
    g_prev = 1'b1;
    for (int k = 0; k < 4000; k++) begin
      cyc();
      busy     = disp_req && !g_prev;
      rst      = ($urandom_range(0, 299) == 0);
      cpu_req  = ($urandom_range(0, 9) < 8);
      cpu_we   = 1'($urandom_range(0, 1));
      cpu_addr = $urandom;
      cpu_wd   = $urandom;
      if (!busy) begin
        disp_req = ($urandom_range(0, 9) < 7);
        case ($urandom_range(0, 9))
          0:       disp_addr = 18'd152099;
          1:       disp_addr = 18'd152100;
          2:       disp_addr = 18'($urandom);
          default: disp_addr = 18'($urandom_range(0, IMG_LAST));
        endcase
      end
      @(negedge clk);
      g_prev = disp_gnt;
    end

    cyc();
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
